register_file_32b_write_combiner: RTL and testbench
===================================================

// Module: register_file_32b_write_combiner
// PURPOSE
//  Upstream write stage for the 64b-write / 32b-read register file.
//  - Accepts 32-bit word writes over a valid/ready handshake.
//  - Pairs lo/hi halves of the same 64-bit row into one 64-bit write.
//  - Lone halves are completed by read-modify-write through one dedicated 32b read port,
//    so the other half of the row is never clobbered.
// PARAMETERS
//  WADDR_WIDTH  5                  row address width of the 64b write port
//  WDATA_WIDTH  64                 write data width; fixed at 2*IDATA_WIDTH
//  IDATA_WIDTH  32                 input word width; equals RF read width
//  IADDR_WIDTH  WADDR_WIDTH+1      word address width; bit 0 selects half (0=lo [31:0], 1=hi [63:32])
//  TIMEOUT      8                  idle cycles a partial row may wait before forced RMW; 0 disables timer
// PORTS
//  clk            in   1            clock
//  rst            in   1            synchronous reset, active-high
//  in_valid       in   1            input write request valid
//  in_ready       out  1            request accepted when in_valid & in_ready at posedge
//  in_addr        in   IADDR_WIDTH  word address of the request
//  in_data        in   IDATA_WIDTH  word data of the request
//  flush          in   1            force completion of any partial row
//  idle           out  1            buffer empty and no write in flight
//  rf_ReadEnable  out  1            RMW read strobe to RF read port
//  rf_ReadAddr    out  IADDR_WIDTH  RMW read word address
//  rf_ReadData    in   IDATA_WIDTH  RMW read data; valid the cycle after rf_ReadEnable
//  WriteEnable    out  1            RF write strobe; one-cycle pulse
//  WriteAddr      out  WADDR_WIDTH  RF row address
//  WriteData      out  WDATA_WIDTH  RF row data
// BEHAVIOUR
//  - Reset state:
//    - FSM=IDLE; buffer valid bits v_lo=v_hi=0; timer=0.
//    - WriteEnable=0, rf_ReadEnable=0; WriteAddr, WriteData, rf_ReadAddr all 0.
//    - idle=1.
//  - Reset behaviour:
//    - Reset mid-operation discards the partial row without writing it.
//    - An already-registered WriteEnable is cleared.
//  - Write outputs (WriteEnable/Addr/Data) are registered.
//  - FSM states: IDLE, HOLD, RMW_RD, RMW_WAIT.
//  - IDLE:
//    - in_ready=1.
//    - On accept: store word in half in_addr[0], row=in_addr[IADDR_WIDTH-1:1], set valid bit, timer=0 -> HOLD.
//  - HOLD:
//    - in_ready=1 iff in_addr row == buffered row.
//    - Accept of the same half: overwrite that half; timer=0; stay in HOLD.
//    - Accept of the missing half:
//      - Next cycle WriteEnable=1 with the full row; valid bits cleared -> IDLE.
//      - Latency from accept to WriteEnable: 1 cycle.
//    - Leave for RMW_RD on any of:
//      - in_valid with a different row (request stalls, in_ready=0);
//      - flush=1;
//      - timer==TIMEOUT with TIMEOUT>0.
//    - Otherwise timer increments; it saturates at TIMEOUT.
//    - Same-row accept and flush in the same cycle: the accept wins; flush is re-evaluated next cycle.
//  - RMW_RD:
//    - in_ready=0.
//    - rf_ReadEnable=1 for exactly 1 cycle, rf_ReadAddr={row, ~present_half} -> RMW_WAIT.
//  - RMW_WAIT:
//    - in_ready=0.
//    - Capture rf_ReadData into the missing half.
//    - Next cycle WriteEnable=1 with the merged row -> IDLE.
//    - A stalled request is accepted in IDLE in that same WriteEnable cycle.
//  - Hazard ordering: any write is issued >=1 cycle before a subsequent RMW read of the same row.
//    This follows from the IDLE->HOLD->RMW_RD minimum path; no bypass is needed.
//  - flush in IDLE: no effect.
//  - idle = (FSM==IDLE) & ~WriteEnable.
//  - Only one RF read is outstanding at any time.
//  - No write is ever issued with only one half valid.
// TESTING
//  - Pair:
//    - Stimulus: write addr 0x06 data 0xAAAA_0000, then addr 0x07 data 0xBBBB_1111 on consecutive cycles.
//    - Response: a single WriteEnable, WriteAddr=3, WriteData=0xBBBB_1111_AAAA_0000; no rf_ReadEnable.
//  - Row switch:
//    - Stimulus: RF row 2 preloaded 0x1234_5678_9ABC_DEF0; write addr 0x04 data 0xCAFE_F00D, then addr 0x10.
//    - Response: rf_ReadAddr=0x05; WriteData=0x1234_5678_CAFE_F00D to row 2; the addr-0x10 request stalls until IDLE.
//  - Timeout:
//    - Stimulus: TIMEOUT=8; single write to addr 0x01 then no traffic.
//    - Response: rf_ReadEnable asserted exactly 9 cycles after accept (8 HOLD-timer cycles + 1); hi half written, lo half preserved.
//  - Overwrite/flush:
//    - Stimulus: addr 0x08 data 1, then addr 0x08 data 2, then flush.
//    - Response: one RMW; lo half of row 4 = 2.
//  - Reset:
//    - Stimulus: rst asserted in RMW_WAIT.
//    - Response: no WriteEnable; idle=1 on the cycle after rst deasserts; RF contents unchanged.

Source files
------------

// File: rtl/register_file_32b_write_combiner.sv
// Write combiner for the 64b-write / 32b-read register file.
// It pairs 32b word writes into full-row writes and completes lone halves by read-modify-write.
module register_file_32b_write_combiner #(
    parameter int WADDR_WIDTH = 5,
    parameter int WDATA_WIDTH = 64,
    parameter int IDATA_WIDTH = 32,
    parameter int IADDR_WIDTH = WADDR_WIDTH + 1,
    parameter int TIMEOUT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IADDR_WIDTH-1:0] in_addr,
    input  logic [IDATA_WIDTH-1:0] in_data,
    input  logic                   flush,
    output logic                   idle,
    output logic                   rf_ReadEnable,
    output logic [IADDR_WIDTH-1:0] rf_ReadAddr,
    input  logic [IDATA_WIDTH-1:0] rf_ReadData,
    output logic                   WriteEnable,
    output logic [WADDR_WIDTH-1:0] WriteAddr,
    output logic [WDATA_WIDTH-1:0] WriteData
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RMW_RD, S_RMW_WAIT} state_t;

    state_t                 state;
    logic [WADDR_WIDTH-1:0] row_p0;
    logic                   v_lo_p0;
    logic                   v_hi_p0;
    logic [IDATA_WIDTH-1:0] lo_p0;
    logic [IDATA_WIDTH-1:0] hi_p0;
    logic [TW-1:0]          timer;

    logic [WADDR_WIDTH-1:0] in_row;
    logic                   in_half;
    logic                   accept;
    logic                   timed_out;

    assign in_row    = in_addr[IADDR_WIDTH-1:1];
    assign in_half   = in_addr[0];
    assign accept    = in_valid & in_ready;
    assign timed_out = (TIMEOUT > 0) && (timer == TMAX);
    assign idle      = (state == S_IDLE) & ~WriteEnable;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_HOLD:  in_ready = (in_row == row_p0);
            default: in_ready = 1'b0;
        endcase
    end

    // Stage p0: half-row data buffer; validity lives in the control block.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (in_half) hi_p0 <= in_data;
            else         lo_p0 <= in_data;
        end
    end

    // Stage p1: control FSM and registered RF read/write strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            row_p0        <= '0;
            v_lo_p0       <= 1'b0;
            v_hi_p0       <= 1'b0;
            timer         <= '0;
            WriteEnable   <= 1'b0;
            WriteAddr     <= '0;
            WriteData     <= '0;
            rf_ReadEnable <= 1'b0;
            rf_ReadAddr   <= '0;
        end else begin
            WriteEnable   <= 1'b0;
            rf_ReadEnable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        row_p0  <= in_row;
                        v_lo_p0 <= ~in_half;
                        v_hi_p0 <= in_half;
                        timer   <= '0;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        if (in_half == v_hi_p0) begin
                            timer <= '0;
                        end else begin
                            WriteEnable <= 1'b1;
                            WriteAddr   <= row_p0;
                            WriteData   <= in_half ? {in_data, lo_p0} : {hi_p0, in_data};
                            v_lo_p0     <= 1'b0;
                            v_hi_p0     <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end else if (in_valid || flush || timed_out) begin
                        // Fetch the absent half; v_lo_p0 set means the hi half is missing.
                        rf_ReadEnable <= 1'b1;
                        rf_ReadAddr   <= {row_p0, v_lo_p0};
                        state         <= S_RMW_RD;
                    end else if (timer != TMAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RMW_RD: begin
                    state <= S_RMW_WAIT;
                end
                S_RMW_WAIT: begin
                    WriteEnable <= 1'b1;
                    WriteAddr   <= row_p0;
                    WriteData   <= v_lo_p0 ? {rf_ReadData, lo_p0} : {hi_p0, rf_ReadData};
                    v_lo_p0     <= 1'b0;
                    v_hi_p0     <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_32b_write_combiner.sv
// Directed bench for the write combiner, with a behavioural 64b-write / 32b-read RF model.
module tb_register_file_32b_write_combiner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_addr;
    logic [31:0] in_data;
    logic        flush;
    logic        idle;
    logic        rf_ReadEnable;
    logic [5:0]  rf_ReadAddr;
    logic [31:0] rf_ReadData;
    logic        WriteEnable;
    logic [4:0]  WriteAddr;
    logic [63:0] WriteData;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [63:0] rf [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [63:0] pl_data = '0;

    register_file_32b_write_combiner dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .flush(flush), .idle(idle),
        .rf_ReadEnable(rf_ReadEnable), .rf_ReadAddr(rf_ReadAddr), .rf_ReadData(rf_ReadData),
        .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        if (WriteEnable) begin
            rf[WriteAddr] <= WriteData;
            wr_cnt <= wr_cnt + 1;
        end
        if (rf_ReadEnable) begin
            rf_ReadData <= rf_ReadAddr[0] ? rf[rf_ReadAddr[5:1]][63:32] : rf[rf_ReadAddr[5:1]][31:0];
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] row, input logic [63:0] data);
        pl_en = 1'b1; pl_addr = row; pl_data = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic wait_we(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (WriteEnable === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_addr = '0; in_data = '0;
        tick(); tick();
        n_cmp++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", WriteEnable); end
        n_cmp++; if (rf_ReadEnable !== 1'b0) begin n_err++; $display("FAIL reset_re: got %b want 0", rf_ReadEnable); end
        n_cmp++; if (WriteAddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %h want 0", WriteAddr); end
        n_cmp++; if (WriteData !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", WriteData); end
        n_cmp++; if (rf_ReadAddr !== 6'd0) begin n_err++; $display("FAIL reset_raddr: got %h want 0", rf_ReadAddr); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pair();
        int w0, r0;
        preload(5'd3, 64'h0);
        w0 = wr_cnt; r0 = rd_cnt;
        in_valid = 1'b1; in_addr = 6'h06; in_data = 32'hAAAA_0000;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pair_ready_lo: got %b want 1", in_ready); end
        tick();
        in_addr = 6'h07; in_data = 32'hBBBB_1111;
        n_cmp++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL pair_no_early_we: got %b want 0", WriteEnable); end
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL pair_busy: got %b want 0", idle); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (WriteEnable !== 1'b1) begin n_err++; $display("FAIL pair_we: got %b want 1", WriteEnable); end
        n_cmp++; if (WriteAddr !== 5'd3) begin n_err++; $display("FAIL pair_waddr: got %h want 3", WriteAddr); end
        n_cmp++; if (WriteData !== 64'hBBBB_1111_AAAA_0000) begin n_err++; $display("FAIL pair_wdata: got %h want bbbb1111aaaa0000", WriteData); end
        tick();
        n_cmp++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL pair_we_pulse: got %b want 0", WriteEnable); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL pair_idle: got %b want 1", idle); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL pair_wr_count: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL pair_rd_count: got %0d want 0", rd_cnt - r0); end
        n_cmp++; if (rf[3] !== 64'hBBBB_1111_AAAA_0000) begin n_err++; $display("FAIL pair_rf: got %h want bbbb1111aaaa0000", rf[3]); end
    endtask

    task automatic test_back_to_back();
        int w0, r0;
        logic [5:0]  addrs [4];
        logic [31:0] datas [4];
        addrs = '{6'h0C, 6'h0D, 6'h0E, 6'h0F};
        datas = '{32'h0000_00C0, 32'h0000_00D1, 32'h0000_00E2, 32'h0000_00F3};
        w0 = wr_cnt; r0 = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = addrs[i]; in_data = datas[i];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (rf[6] !== 64'h0000_00D1_0000_00C0) begin n_err++; $display("FAIL b2b_row6: got %h want 000000d1000000c0", rf[6]); end
        n_cmp++; if (rf[7] !== 64'h0000_00F3_0000_00E2) begin n_err++; $display("FAIL b2b_row7: got %h want 000000f3000000e2", rf[7]); end
        n_cmp++; if (wr_cnt - w0 !== 2) begin n_err++; $display("FAIL b2b_wr_count: got %0d want 2", wr_cnt - w0); end
        n_cmp++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL b2b_rd_count: got %0d want 0", rd_cnt - r0); end
    endtask

    task automatic test_row_switch();
        int r0;
        bit seen;
        preload(5'd2, 64'h1234_5678_9ABC_DEF0);
        preload(5'd8, 64'h7777_8888_0000_0000);
        r0 = rd_cnt;
        in_valid = 1'b1; in_addr = 6'h04; in_data = 32'hCAFE_F00D;
        tick();
        in_addr = 6'h10; in_data = 32'h5555_6666;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rs_stall_hold: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (rf_ReadEnable !== 1'b1) begin n_err++; $display("FAIL rs_re: got %b want 1", rf_ReadEnable); end
        n_cmp++; if (rf_ReadAddr !== 6'h05) begin n_err++; $display("FAIL rs_raddr: got %h want 05", rf_ReadAddr); end
        tick();
        n_cmp++; if (rf_ReadEnable !== 1'b0) begin n_err++; $display("FAIL rs_re_pulse: got %b want 0", rf_ReadEnable); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rs_stall_wait: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (WriteEnable !== 1'b1) begin n_err++; $display("FAIL rs_we: got %b want 1", WriteEnable); end
        n_cmp++; if (WriteAddr !== 5'd2) begin n_err++; $display("FAIL rs_waddr: got %h want 2", WriteAddr); end
        n_cmp++; if (WriteData !== 64'h1234_5678_CAFE_F00D) begin n_err++; $display("FAIL rs_wdata: got %h want 12345678cafef00d", WriteData); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rs_ready_release: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL rs_stalled_accepted: got idle %b want 0", idle); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_we(10, seen);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rs_flush_timeout: got no write want write within 10 cycles"); end
        n_cmp++; if (WriteData !== 64'h7777_8888_5555_6666 || WriteAddr !== 5'd8) begin n_err++; $display("FAIL rs_flush_write: got row %h data %h want row 08 data 7777888855556666", WriteAddr, WriteData); end
        tick();
        n_cmp++; if (rd_cnt - r0 !== 2) begin n_err++; $display("FAIL rs_rd_count: got %0d want 2", rd_cnt - r0); end
        n_cmp++; if (rf[2] !== 64'h1234_5678_CAFE_F00D) begin n_err++; $display("FAIL rs_rf_row2: got %h want 12345678cafef00d", rf[2]); end
    endtask

    task automatic test_timeout();
        int lat;
        bit seen;
        preload(5'd0, 64'h1111_2222_3333_4444);
        lat = 0;
        in_valid = 1'b1; in_addr = 6'h01; in_data = 32'hFEED_BEEF;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rf_ReadEnable === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL to_latency: got %0d want 9", lat); end
        n_cmp++; if (rf_ReadAddr !== 6'h00) begin n_err++; $display("FAIL to_raddr: got %h want 00", rf_ReadAddr); end
        wait_we(5, seen);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL to_write_timeout: got no write want write within 5 cycles"); end
        n_cmp++; if (WriteData !== 64'hFEED_BEEF_3333_4444) begin n_err++; $display("FAIL to_wdata: got %h want feedbeef33334444", WriteData); end
        tick();
    endtask

    task automatic test_overwrite_flush();
        int w0, r0;
        bit seen;
        preload(5'd4, 64'hABCD_0000_FFFF_FFFF);
        w0 = wr_cnt; r0 = rd_cnt;
        in_valid = 1'b1; in_addr = 6'h08; in_data = 32'd1;
        tick();
        in_data = 32'd2; flush = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (rf_ReadEnable !== 1'b0) begin n_err++; $display("FAIL ow_accept_wins: got re %b want 0", rf_ReadEnable); end
        tick();
        flush = 1'b0;
        n_cmp++; if (rf_ReadEnable !== 1'b1) begin n_err++; $display("FAIL ow_flush_re: got %b want 1", rf_ReadEnable); end
        n_cmp++; if (rf_ReadAddr !== 6'h09) begin n_err++; $display("FAIL ow_raddr: got %h want 09", rf_ReadAddr); end
        wait_we(5, seen);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL ow_write_timeout: got no write want write within 5 cycles"); end
        n_cmp++; if (WriteData !== 64'hABCD_0000_0000_0002 || WriteAddr !== 5'd4) begin n_err++; $display("FAIL ow_write: got row %h data %h want row 04 data abcd000000000002", WriteAddr, WriteData); end
        tick();
        n_cmp++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin n_err++; $display("FAIL ow_counts: got rd %0d wr %0d want rd 1 wr 1", rd_cnt - r0, wr_cnt - w0); end
        flush = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (idle !== 1'b1 || rd_cnt - r0 !== 1) begin n_err++; $display("FAIL idle_flush: got idle %b rd %0d want idle 1 rd 1", idle, rd_cnt - r0); end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w0;
        preload(5'd5, 64'h0F0F_0F0F_F0F0_F0F0);
        w0 = wr_cnt;
        in_valid = 1'b1; in_addr = 6'h0A; in_data = 32'h0000_0001;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b0 || rf_ReadEnable !== 1'b0) begin n_err++; $display("FAIL rm_in_wait: got ready %b re %b want 0 0", in_ready, rf_ReadEnable); end
        rst = 1'b1;
        tick();
        n_cmp++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL rm_we_in_reset: got %b want 0", WriteEnable); end
        rst = 1'b0;
        tick();
        n_cmp++; if (idle !== 1'b1 || WriteEnable !== 1'b0) begin n_err++; $display("FAIL rm_idle_after: got idle %b we %b want 1 0", idle, WriteEnable); end
        tick(); tick();
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL rm_no_write: got %0d writes want 0", wr_cnt - w0); end
        n_cmp++; if (rf[5] !== 64'h0F0F_0F0F_F0F0_F0F0) begin n_err++; $display("FAIL rm_rf_kept: got %h want 0f0f0f0ff0f0f0f0", rf[5]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_addr = '0; in_data = '0;
        test_reset();
        test_pair();
        test_back_to_back();
        test_row_switch();
        test_timeout();
        test_overwrite_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
